idma_obi_mem_responder: RTL

Synthesizable OBI subordinate with backing memory, the responder end of the iDMA backend's OBI read and write manager ports. It accepts A-channel requests and answers each on the R channel after a configurable fixed latency. It limits outstanding transactions by withholding grant, and flags out-of-range accesses with an error response. It is used in backend simulation benches and FPGA bring-up, where it stands in for the behavioural OBI read and write models.

---
 rtl/idma_obi_mem_responder_pkg.sv | 12 +
 rtl/idma_obi_mem_resp_pipe.sv | 39 +++
 rtl/idma_obi_mem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/idma_obi_mem_responder_pkg.sv
// Shared limits and helpers for the OBI memory responder and its response delay line.
package idma_obi_mem_responder_pkg;

    localparam int unsigned MaxMemLatency  = 15;
    localparam int unsigned MaxNumReqOutst = 16;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/idma_obi_mem_resp_pipe.sv
// Fixed-depth valid/payload delay line with synchronous clear; shifts every cycle, never stalls.
module idma_obi_mem_resp_pipe #(
    parameter int unsigned Depth     = 1,
    parameter type         payload_t = logic
) (
    input  logic     clk_i,
    input  logic     clr_i,
    input  logic     valid_i,
    input  payload_t payload_i,
    output logic     valid_o,
    output payload_t payload_o
);

    logic [Depth-1:0] valid_q;
    payload_t         payload_q [Depth];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // NOTE: payload stages are not reset; the matching valid bit qualifies them.
    always_ff @(posedge clk_i) begin
        payload_q[0] <= payload_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            payload_q[i] <= payload_q[i-1];
        end
    end

    assign valid_o   = valid_q[Depth-1];
    assign payload_o = payload_q[Depth-1];

endmodule

// File: rtl/idma_obi_mem_responder.sv
// OBI subordinate with backing memory: byte-enable writes, fixed-latency in-order
// responses, grant throttled by an outstanding-transaction counter.
module idma_obi_mem_responder
    import idma_obi_mem_responder_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned IdWidth     = 12,
    parameter int unsigned MemDepth    = 1024,
    parameter int unsigned MemLatency  = 0,
    parameter int unsigned NumReqOutst = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o
);

    localparam int unsigned StrbWidth   = DataWidth / 8;
    localparam int unsigned OffsetWidth = (StrbWidth > 1) ? $clog2(StrbWidth) : 0;
    localparam int unsigned IndexWidth  = $clog2(MemDepth);
    localparam int unsigned HiLsb       = OffsetWidth + IndexWidth;
    localparam int unsigned CntWidth    = cnt_width(NumReqOutst);
    localparam logic [CntWidth-1:0] MaxOutst = CntWidth'(NumReqOutst);

    if (DataWidth == 0 || DataWidth % 8 != 0) begin : gen_dw_check
        $error("DataWidth must be a non-zero multiple of 8");
    end
    if (MemDepth < 2 || (MemDepth & (MemDepth - 1)) != 0) begin : gen_depth_check
        $error("MemDepth must be a power of two and at least 2");
    end
    if (MemLatency > MaxMemLatency) begin : gen_lat_check
        $error("MemLatency must be in 0..15");
    end
    if (NumReqOutst < 1 || NumReqOutst > MaxNumReqOutst) begin : gen_outst_check
        $error("NumReqOutst must be in 1..16");
    end
    if (AddrWidth < HiLsb) begin : gen_aw_check
        $error("AddrWidth too narrow for MemDepth and DataWidth");
    end

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } resp_t;

    logic [DataWidth-1:0]  mem_q [MemDepth];
    logic [CntWidth-1:0]   outst_q, outst_d;
    logic [IndexWidth-1:0] word_idx;
    logic                  in_range;
    logic                  handshake;
    resp_t                 resp_in, resp_out;

    assign word_idx  = addr_i[OffsetWidth +: IndexWidth];
    assign in_range  = ~|(addr_i >> HiLsb);
    assign gnt_o     = req_i & (outst_q < MaxOutst);
    assign handshake = req_i & gnt_o;

    // NOTE: the memory array is deliberately not reset; only control state is.
    always_ff @(posedge clk_i) begin
        if (handshake && !rst_i && in_range && we_i) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is taken before this edge's write commits, so it reflects earlier grants only.
    always_comb begin
        resp_in.rdata = (in_range && !we_i) ? mem_q[word_idx] : '0;
        resp_in.rid   = aid_i;
        resp_in.err   = ~in_range;
    end

    idma_obi_mem_resp_pipe #(
        .Depth     (MemLatency + 1),
        .payload_t (resp_t)
    ) i_resp_pipe (
        .clk_i     (clk_i),
        .clr_i     (rst_i),
        .valid_i   (handshake),
        .payload_i (resp_in),
        .valid_o   (rvalid_o),
        .payload_o (resp_out)
    );

    assign rdata_o = rvalid_o ? resp_out.rdata : '0;
    assign rid_o   = rvalid_o ? resp_out.rid   : '0;
    assign err_o   = rvalid_o ? resp_out.err   : 1'b0;

    // NOTE: outst_d gets a default first so no path through this block can infer a latch.
    always_comb begin
        outst_d = outst_q;
        if (handshake && !rvalid_o) begin
            outst_d = outst_q + 1'b1;
        end else if (!handshake && rvalid_o) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

endmodule
